// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared state type and index helper for the router output arbiters
package noc_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    // Next index in a ring of n entries; works for any n, not just powers of two
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 == n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request at or after start_i, searching cyclically
module rr_priority_picker
    import noc_arb_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int IDX_WIDTH = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] start_i,
    output logic                 found_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    localparam logic [IDX_WIDTH:0] NP = (IDX_WIDTH + 1)'(N_PORTS);

    logic [2*N_PORTS-1:0] w_dbl;
    logic [N_PORTS-1:0]   w_rot;
    logic [IDX_WIDTH-1:0] w_off;
    logic [IDX_WIDTH:0]   w_sum;

    assign w_dbl   = {req_i, req_i} >> start_i;
    assign w_rot   = w_dbl[N_PORTS-1:0];
    assign found_o = |w_rot;

    // lowest set bit of the rotated vector is the nearest requester at or after start_i
    always_comb begin
        w_off = '0;
        for (int i = N_PORTS - 1; i >= 0; i--)
            if (w_rot[i]) w_off = IDX_WIDTH'(i);
    end

    assign w_sum = {1'b0, start_i} + {1'b0, w_off};
    assign idx_o = (w_sum >= NP) ? IDX_WIDTH'(w_sum - NP) : w_sum[IDX_WIDTH-1:0];

endmodule

// File: rtl/noc_packet_arbiter.sv
// noc_packet_arbiter: round-robin wormhole arbiter holding a grant until the tail flit handshakes
module noc_packet_arbiter
    import noc_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_PORTS    = 4,
    parameter int IDX_WIDTH  = $clog2(N_PORTS)
) (
    input  logic                               clk_i,
    input  logic                               arstn_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0] data_i,
    input  logic [N_PORTS-1:0]                 valid_i,
    input  logic [N_PORTS-1:0]                 last_i,
    output logic [N_PORTS-1:0]                 ready_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic                               valid_o,
    output logic                               last_o,
    input  logic                               ready_i,
    output logic [IDX_WIDTH-1:0]               grant_idx_o,
    output logic                               busy_o
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [IDX_WIDTH-1:0] r_rr_ptr;
    logic [IDX_WIDTH-1:0] r_lock_idx;
    logic [IDX_WIDTH-1:0] w_rr_nxt;
    logic [IDX_WIDTH-1:0] w_lock_nxt;
    logic [IDX_WIDTH-1:0] w_pick_idx;
    logic [IDX_WIDTH-1:0] w_sel;
    logic [IDX_WIDTH-1:0] w_sel_inc;
    logic                 w_found;
    logic                 w_locked;
    logic                 w_active;
    logic                 w_tail;

    rr_priority_picker #(
        .N_PORTS   (N_PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .req_i   (valid_i),
        .start_i (r_rr_ptr),
        .found_o (w_found),
        .idx_o   (w_pick_idx)
    );

    assign w_locked    = r_state == LOCKED;
    assign w_sel       = w_locked ? r_lock_idx : w_pick_idx;
    assign w_active    = w_locked | w_found;
    assign valid_o     = valid_i[w_sel];
    assign data_o      = data_i[w_sel];
    assign last_o      = last_i[w_sel];
    assign grant_idx_o = w_sel;
    assign busy_o      = w_locked;
    assign w_tail      = valid_o & ready_i & last_o;
    assign w_sel_inc   = IDX_WIDTH'(wrap_inc(int'(w_sel), N_PORTS));

    // only the selected port sees the downstream ready; nothing is selected when idle with no request
    always_comb begin
        ready_o        = '0;
        ready_o[w_sel] = ready_i & w_active;
    end

    // a tail handshake frees the output and advances priority; anything else holds or takes the lock
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_lock_nxt  = r_lock_idx;
        if (w_active) begin
            if (w_tail) begin
                w_state_nxt = IDLE;
                w_rr_nxt    = w_sel_inc;
            end else if (!w_locked) begin
                w_state_nxt = LOCKED;
                w_lock_nxt  = w_sel;
            end
        end
    end

    // state, round-robin pointer and locked port registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock_idx <= w_lock_nxt;
        end
    end

endmodule
